// File: rtl/fir_stream_sched.sv
// Stream scheduler around the free-running 24-cycle folded FIR: input/output FIFOs, start/prime FSM, feed and capture.
// Optional statistics counters are compiled in when FIR_SCHED_STAT_EN is defined.
module fir_stream_sched #(
  parameter int DW        = 16,
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 4,
  parameter int PRIME_LVL = 2,
  parameter int DISCARD   = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ctrl_en,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          fir_en,
  output logic [DW-1:0] fir_din,
  input  logic          fir_sample_in,
  input  logic          fir_sample_out,
  input  logic [DW-1:0] fir_dout,
  output logic [1:0]    state,
  output logic          underrun,
  output logic          overflow,
  input  logic          clr_flags
`ifdef FIR_SCHED_STAT_EN
  ,
  output logic [15:0]   in_cnt,
  output logic [15:0]   out_cnt,
  output logic [15:0]   urun_cnt,
  output logic [15:0]   ovf_cnt
`endif
);

  localparam int IA_W = $clog2(IN_DEPTH);
  localparam int IC_W = IA_W + 1;
  localparam int OA_W = $clog2(OUT_DEPTH);
  localparam int OC_W = OA_W + 1;
  localparam int DC_W = (DISCARD < 1) ? 1 : $clog2(DISCARD + 1);

  localparam logic [IC_W-1:0] IN_FULL_LVL  = IC_W'(IN_DEPTH);
  localparam logic [OC_W-1:0] OUT_FULL_LVL = OC_W'(OUT_DEPTH);
  localparam logic [IC_W-1:0] PRIME_C      = IC_W'(PRIME_LVL);
  localparam logic [DC_W-1:0] DISC_C       = DC_W'(DISCARD);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_PRIME = 2'b01,
    ST_RUN   = 2'b10,
    ST_HALT  = 2'b11
  } state_t;

  state_t          state_q, state_d;
  logic            fir_en_q, fir_en_d;
  logic [DC_W-1:0] disc_q, disc_d;
  logic            underrun_q, underrun_d;
  logic            overflow_q, overflow_d;

  logic [IA_W-1:0] in_rd_q, in_rd_d, in_wr_q, in_wr_d;
  logic [IC_W-1:0] in_lvl_q, in_lvl_d;
  logic [OA_W-1:0] out_rd_q, out_rd_d, out_wr_q, out_wr_d;
  logic [OC_W-1:0] out_lvl_q, out_lvl_d;

  logic [DW-1:0] in_mem_q  [IN_DEPTH];
  logic [DW-1:0] out_mem_q [OUT_DEPTH];

  logic in_empty, in_full, out_empty, out_full;
  logic in_push, in_pop, out_push, out_pop;
  logic is_run, is_halt, slot, cap, keep, urun_set, ovf_set;

  always_comb begin
    in_empty  = (in_lvl_q == '0);
    in_full   = (in_lvl_q == IN_FULL_LVL);
    out_empty = (out_lvl_q == '0);
    out_full  = (out_lvl_q == OUT_FULL_LVL);
    is_run    = (state_q == ST_RUN);
    is_halt   = (state_q == ST_HALT);

    s_ready   = !rst && !in_full;
    m_valid   = !out_empty;
    in_push   = s_valid && s_ready;
    out_pop   = m_valid && m_ready;

    slot      = is_run && fir_sample_in;
    in_pop    = slot && !in_empty;
    urun_set  = slot && in_empty;

    // A result landing on a full FIFO still fits when the same cycle pops.
    cap       = fir_sample_out && (is_run || is_halt);
    keep      = cap && (disc_q == '0) && is_run;
    out_push  = keep && (!out_full || out_pop);
    ovf_set   = keep && out_full && !out_pop;
  end

  always_comb begin
    in_rd_d  = in_rd_q  + IA_W'(in_pop);
    in_wr_d  = in_wr_q  + IA_W'(in_push);
    in_lvl_d = in_lvl_q + IC_W'(in_push) - IC_W'(in_pop);
    out_rd_d  = out_rd_q  + OA_W'(out_pop);
    out_wr_d  = out_wr_q  + OA_W'(out_push);
    out_lvl_d = out_lvl_q + OC_W'(out_push) - OC_W'(out_pop);
  end

  always_comb begin
    state_d  = state_q;
    fir_en_d = fir_en_q;
    disc_d   = disc_q;
    if (cap && (disc_q != '0)) begin
      disc_d = disc_q - DC_W'(1);
    end
    unique case (state_q)
      ST_IDLE: begin
        if (ctrl_en) state_d = ST_PRIME;
      end
      ST_PRIME: begin
        if (in_lvl_d >= PRIME_C) begin
          state_d  = ST_RUN;
          fir_en_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (!ctrl_en) state_d = ST_HALT;
      end
      ST_HALT: begin
        // Results already in flight when we resume belong to the halted period.
        if (ctrl_en) begin
          state_d = ST_RUN;
          disc_d  = DISC_C;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    underrun_d = clr_flags ? 1'b0 : (underrun_q || urun_set);
    overflow_d = clr_flags ? 1'b0 : (overflow_q || ovf_set);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      fir_en_q   <= 1'b0;
      disc_q     <= DISC_C;
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
      in_rd_q    <= '0;
      in_wr_q    <= '0;
      in_lvl_q   <= '0;
      out_rd_q   <= '0;
      out_wr_q   <= '0;
      out_lvl_q  <= '0;
    end else begin
      state_q    <= state_d;
      fir_en_q   <= fir_en_d;
      disc_q     <= disc_d;
      underrun_q <= underrun_d;
      overflow_q <= overflow_d;
      in_rd_q    <= in_rd_d;
      in_wr_q    <= in_wr_d;
      in_lvl_q   <= in_lvl_d;
      out_rd_q   <= out_rd_d;
      out_wr_q   <= out_wr_d;
      out_lvl_q  <= out_lvl_d;
    end
  end

  // FIFO storage carries data only; validity comes from the level counters.
  always_ff @(posedge clk) begin
    if (in_push)  in_mem_q[in_wr_q]   <= s_data;
    if (out_push) out_mem_q[out_wr_q] <= fir_dout;
  end

  always_comb begin
    state    = state_q;
    fir_en   = fir_en_q;
    underrun = underrun_q;
    overflow = overflow_q;
    fir_din  = (is_run && !in_empty) ? in_mem_q[in_rd_q] : '0;
    m_data   = out_empty ? '0 : out_mem_q[out_rd_q];
  end

`ifdef FIR_SCHED_STAT_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    if (en && (v != 16'hFFFF)) return v + 16'd1;
    return v;
  endfunction

  logic [15:0] in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
  logic [15:0] urun_cnt_q, urun_cnt_d, ovf_cnt_q, ovf_cnt_d;

  always_comb begin
    in_cnt_d   = clr_flags ? 16'd0 : sat_inc(in_cnt_q, in_push);
    out_cnt_d  = clr_flags ? 16'd0 : sat_inc(out_cnt_q, out_pop);
    urun_cnt_d = clr_flags ? 16'd0 : sat_inc(urun_cnt_q, urun_set);
    ovf_cnt_d  = clr_flags ? 16'd0 : sat_inc(ovf_cnt_q, ovf_set);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_cnt_q   <= '0;
      out_cnt_q  <= '0;
      urun_cnt_q <= '0;
      ovf_cnt_q  <= '0;
    end else begin
      in_cnt_q   <= in_cnt_d;
      out_cnt_q  <= out_cnt_d;
      urun_cnt_q <= urun_cnt_d;
      ovf_cnt_q  <= ovf_cnt_d;
    end
  end

  assign in_cnt   = in_cnt_q;
  assign out_cnt  = out_cnt_q;
  assign urun_cnt = urun_cnt_q;
  assign ovf_cnt  = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_fir_stream_sched.sv
// Directed bench for fir_stream_sched; the bench itself plays the FIR by pulsing sample_in/sample_out.
module tb_fir_stream_sched;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          ctrl_en;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          fir_en;
  logic [DW-1:0] fir_din;
  logic          fir_sample_in;
  logic          fir_sample_out;
  logic [DW-1:0] fir_dout;
  logic [1:0]    state;
  logic          underrun;
  logic          overflow;
  logic          clr_flags;
`ifdef FIR_SCHED_STAT_EN
  logic [15:0]   in_cnt, out_cnt, urun_cnt, ovf_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fir_stream_sched #(
    .DW(DW), .IN_DEPTH(4), .OUT_DEPTH(4), .PRIME_LVL(2), .DISCARD(1)
  ) dut (
    .clk(clk), .rst(rst), .ctrl_en(ctrl_en),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .fir_en(fir_en), .fir_din(fir_din),
    .fir_sample_in(fir_sample_in), .fir_sample_out(fir_sample_out), .fir_dout(fir_dout),
    .state(state), .underrun(underrun), .overflow(overflow), .clr_flags(clr_flags)
`ifdef FIR_SCHED_STAT_EN
    , .in_cnt(in_cnt), .out_cnt(out_cnt), .urun_cnt(urun_cnt), .ovf_cnt(ovf_cnt)
`endif
  );

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] v);
    s_valid = 1'b1;
    s_data  = v;
    tick();
    s_valid = 1'b0;
    s_data  = '0;
  endtask

  task automatic slot_in();
    fir_sample_in = 1'b1;
    tick();
    fir_sample_in = 1'b0;
  endtask

  task automatic slot_out(input logic [DW-1:0] v);
    fir_sample_out = 1'b1;
    fir_dout       = v;
    tick();
    fir_sample_out = 1'b0;
    fir_dout       = '0;
  endtask

  task automatic pop_chk(input string tag, input logic [DW-1:0] exp);
    chk_val(tag, {15'd0, m_valid, m_data}, {15'd0, 1'b1, exp});
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; ctrl_en = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    fir_sample_in = 1'b0; fir_sample_out = 1'b0; fir_dout = '0; clr_flags = 1'b0;
    tick(); tick();

    chk_val("rst_outs", {s_ready, m_valid, fir_en, underrun, overflow, state}, 32'd0);
    chk_val("rst_data", {m_data, fir_din}, 32'd0);
    rst = 1'b0;
    #1;
    chk_val("s_ready_idle", s_ready, 1);

    // Prime: two pushes start the FIR
    ctrl_en = 1'b1;
    tick();
    chk_val("st_prime", state, 2'b01);
    push(16'h0100);
    chk_val("prime_1", {fir_en, state}, {1'b0, 2'b01});
    push(16'h0200);
    chk_val("prime_2_run", {fir_en, state}, {1'b1, 2'b10});
    chk_val("din_first", fir_din, 16'h0100);
    slot_in();
    chk_val("din_second", fir_din, 16'h0200);
    slot_in();
    chk_val("din_empty", {fir_din, 15'd0, underrun}, 32'd0);

    // Underrun and clear priority
    slot_in();
    chk_val("urun_set", underrun, 1);
    clr_flags = 1'b1;
    tick();
    chk_val("urun_clr", underrun, 0);
    fir_sample_in = 1'b1;
    tick();
    fir_sample_in = 1'b0;
    clr_flags = 1'b0;
    chk_val("urun_clr_prio", underrun, 0);

    // Impulse: first result discarded, then coefficients/2 appear
    push(16'h4000);
    chk_val("din_impulse", fir_din, 16'h4000);
    slot_in();
    slot_out(16'h1111);
    chk_val("discard_first", m_valid, 0);
    slot_out(16'h0083);
    slot_out(16'h00BF);
    pop_chk("imp_y0", 16'h0083);
    pop_chk("imp_y1", 16'h00BF);
    chk_val("imp_empty", m_valid, 0);

    // Overflow with downstream stalled
    for (int i = 1; i <= 5; i++) begin
      slot_out(16'h0A00 + 16'(i));
      if (i == 4) chk_val("ovf_before", overflow, 0);
    end
    chk_val("ovf_set", overflow, 1);
    for (int i = 1; i <= 4; i++) pop_chk("ovf_drain", 16'h0A00 + 16'(i));
    chk_val("ovf_drained", m_valid, 0);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    chk_val("ovf_clr", overflow, 0);

    // Full FIFO with a pop in the same cycle still accepts the result
    for (int i = 1; i <= 4; i++) slot_out(16'h0B00 + 16'(i));
    m_ready = 1'b1; fir_sample_out = 1'b1; fir_dout = 16'h0B05;
    tick();
    m_ready = 1'b0; fir_sample_out = 1'b0; fir_dout = '0;
    chk_val("full_pop_push", {15'd0, overflow, m_data}, {15'd0, 1'b0, 16'h0B02});
    for (int i = 2; i <= 5; i++) pop_chk("fpp_drain", 16'h0B00 + 16'(i));

    // Halt and resume
    ctrl_en = 1'b0;
    tick();
    chk_val("st_halt", state, 2'b11);
    push(16'h0300);
    chk_val("halt_din", fir_din, 16'h0000);
    slot_in();
    chk_val("halt_no_urun", underrun, 0);
    slot_out(16'h7777);
    chk_val("halt_drop", m_valid, 0);
    ctrl_en = 1'b1;
    tick();
    chk_val("resume", {fir_din, 14'd0, state}, {16'h0300, 14'd0, 2'b10});
    slot_out(16'hDEAD);
    chk_val("resume_discard", m_valid, 0);
    slot_out(16'h0555);
    chk_val("resume_keep", {15'd0, m_valid, m_data}, {15'd0, 1'b1, 16'h0555});

    // Asynchronous reset mid-stream
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk_val("async_rst", {m_data, 9'd0, s_ready, m_valid, fir_en, underrun, overflow, state},
            32'd0);
    chk_val("async_rst_din", fir_din, 16'h0000);
    tick();
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
